// File: rtl/ddr3_ui_burst_model_if.sv
// DDR3 controller user-port bundle: command, write-data, read-data and refresh/status signals.
// master = AXI/cache bridge side, slave = memory model side.
interface ddr3_ui_burst_model_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 28
);
    logic [2:0]          cmd;
    logic                cmd_en;
    logic [ADDR_W-1:0]   addr;
    logic [5:0]          app_burst_number;
    logic                cmd_ready;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_data_en;
    logic                wr_data_end;
    logic [DATA_W/8-1:0] wr_data_mask;
    logic                wr_data_rdy;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_data_valid;
    logic                rd_data_end;
    logic                ref_req;
    logic                ref_ack;
    logic                init_calib_complete;
    logic                proto_err;

    modport master (
        output cmd, cmd_en, addr, app_burst_number,
        output wr_data, wr_data_en, wr_data_end, wr_data_mask, ref_req,
        input  cmd_ready, wr_data_rdy, rd_data, rd_data_valid, rd_data_end,
        input  ref_ack, init_calib_complete, proto_err
    );

    modport slave (
        input  cmd, cmd_en, addr, app_burst_number,
        input  wr_data, wr_data_en, wr_data_end, wr_data_mask, ref_req,
        output cmd_ready, wr_data_rdy, rd_data, rd_data_valid, rd_data_end,
        output ref_ack, init_calib_complete, proto_err
    );
endinterface

// File: rtl/ddr3_ui_burst_model.sv
// Cycle-accurate DDR3 user-interface model: calibration, masked burst writes, pipelined burst reads, refresh.
// Read beats return RD_LATENCY cycles after issue; cmd_ready drops while a burst or refresh is in progress.
module ddr3_ui_burst_model #(
    parameter int DATA_W       = 128,
    parameter int ADDR_W       = 28,
    parameter int DEPTH        = 256,
    parameter int CALIB_CYCLES = 8,
    parameter int RD_LATENCY   = 4,
    parameter int REF_CYCLES   = 6
) (
    input  logic                  memory_clk,
    input  logic                  rst_n,
    ddr3_ui_burst_model_if.slave  ui
);
    localparam int SH    = $clog2(DATA_W / 16);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REF_CYCLES - 1);

    typedef enum logic [2:0] {S_CALIB, S_IDLE, S_WRITE, S_READ, S_REFRESH} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [5:0]         r_beat;
    logic [5:0]         r_len_m1;
    logic               r_calib;
    logic               r_wr_rdy;
    logic               r_ref_ack;
    logic               r_proto;
    logic               r_pipe_vld [RD_LATENCY];
    logic               r_pipe_end [RD_LATENCY];
    logic [DATA_W-1:0]  r_pipe_dat [RD_LATENCY];

    // Backing store survives rst_n so data written before a reset can still be read afterwards.
    logic [DATA_W-1:0]  r_mem [DEPTH] = '{default: '0};

    logic               w_cmd_rdy;
    logic               w_wr_take;
    logic               w_last;
    logic               w_err;
    logic [IDX_W-1:0]   w_cmd_idx;

    assign w_cmd_rdy = (r_state == S_IDLE) && !ui.ref_req;
    assign w_wr_take = (r_state == S_WRITE) && ui.wr_data_en;
    assign w_last    = (r_beat == r_len_m1);
    assign w_cmd_idx = IDX_W'(ADDR_W'(ui.addr) >> SH);
    // Commands are silently ignored during calibration, so they do not count as protocol errors there.
    assign w_err     = (ui.cmd_en && !w_cmd_rdy && (r_state != S_CALIB))
                     || (ui.wr_data_en && (r_state != S_WRITE))
                     || (w_wr_take && (ui.wr_data_end != w_last));

    always_ff @(posedge memory_clk) begin
        if (w_wr_take) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (!ui.wr_data_mask[b]) r_mem[r_idx][b*8 +: 8] <= ui.wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge memory_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CALIB;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_beat    <= '0;
            r_len_m1  <= '0;
            r_calib   <= 1'b0;
            r_wr_rdy  <= 1'b0;
            r_ref_ack <= 1'b0;
            r_proto   <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_end[i] <= 1'b0;
                r_pipe_dat[i] <= '0;
            end
        end else begin
            if (w_err) r_proto <= 1'b1;

            // Read pipeline drains every cycle regardless of FSM state.
            r_pipe_vld[0] <= 1'b0;
            r_pipe_end[0] <= 1'b0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_end[i] <= r_pipe_end[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end

            case (r_state)
                S_CALIB: begin
                    if (r_cnt == CALIB_LAST) begin
                        r_calib <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (ui.ref_req) begin
                        r_cnt     <= '0;
                        r_ref_ack <= (REF_LAST == '0);
                        r_state   <= S_REFRESH;
                    end else if (ui.cmd_en) begin
                        r_idx    <= w_cmd_idx;
                        r_len_m1 <= ui.app_burst_number;
                        r_beat   <= '0;
                        if (ui.cmd == 3'd0) begin
                            r_wr_rdy <= 1'b1;
                            r_state  <= S_WRITE;
                        end else if (ui.cmd == 3'd1) begin
                            r_state  <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (ui.wr_data_en) begin
                        r_idx  <= r_idx + 1'b1;
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_wr_rdy <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_READ: begin
                    r_pipe_vld[0] <= 1'b1;
                    r_pipe_end[0] <= w_last;
                    r_pipe_dat[0] <= r_mem[r_idx];
                    r_idx         <= r_idx + 1'b1;
                    r_beat        <= r_beat + 1'b1;
                    if (w_last) r_state <= S_IDLE;
                end
                S_REFRESH: begin
                    if (r_cnt == REF_LAST) begin
                        r_ref_ack <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_ref_ack <= ((r_cnt + 1'b1) == REF_LAST);
                    end
                end
                default: r_state <= S_CALIB;
            endcase
        end
    end

    assign ui.cmd_ready           = w_cmd_rdy;
    assign ui.wr_data_rdy         = r_wr_rdy;
    assign ui.rd_data             = r_pipe_dat[RD_LATENCY-1];
    assign ui.rd_data_valid       = r_pipe_vld[RD_LATENCY-1];
    assign ui.rd_data_end         = r_pipe_end[RD_LATENCY-1];
    assign ui.ref_ack             = r_ref_ack;
    assign ui.init_calib_complete = r_calib;
    assign ui.proto_err           = r_proto;
endmodule

// File: tb/tb_ddr3_ui_burst_model.sv
// Directed bench for ddr3_ui_burst_model: single-beat vector table plus burst, refresh, error and reset sequences.
module tb_ddr3_ui_burst_model;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 28;
    localparam int RD_LAT = 4;

    logic memory_clk = 1'b0;
    logic rst_n      = 1'b0;
    always #5 memory_clk = ~memory_clk;

    ddr3_ui_burst_model_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ui ();

    ddr3_ui_burst_model #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(256),
        .CALIB_CYCLES(8), .RD_LATENCY(RD_LAT), .REF_CYCLES(6)
    ) dut (
        .memory_clk(memory_clk),
        .rst_n     (rst_n),
        .ui        (ui)
    );

    typedef struct {
        logic [27:0]  addr;
        logic [127:0] wdat;
        logic [15:0]  mask;
        logic [127:0] exp;
    } vec_t;

    vec_t         vt [5];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] cq [$];
    logic         ce [$];
    int           cj [$];
    logic [127:0] bw [4];
    logic [127:0] dw [4];
    logic [127:0] pre_val;
    logic [127:0] exp_v;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic [2:0] c, input logic [27:0] a, input logic [5:0] bn);
        int guard = 0;
        while (!ui.cmd_ready && guard < 50) begin
            @(negedge memory_clk);
            guard++;
        end
        chk("cmd_ready before issue", ui.cmd_ready, 1);
        ui.cmd = c; ui.addr = a; ui.app_burst_number = bn; ui.cmd_en = 1'b1;
        @(posedge memory_clk);
        @(negedge memory_clk);
        ui.cmd_en = 1'b0;
    endtask

    task automatic write_beat(input logic [127:0] d, input logic [15:0] m, input logic e);
        ui.wr_data = d; ui.wr_data_mask = m; ui.wr_data_end = e; ui.wr_data_en = 1'b1;
        @(negedge memory_clk);
        ui.wr_data_en = 1'b0; ui.wr_data_end = 1'b0; ui.wr_data_mask = '0;
    endtask

    // j = 0 is the negedge right after the accepting edge.
    task automatic collect(input int n);
        cq.delete(); ce.delete(); cj.delete();
        for (int j = 0; j < n; j++) begin
            if (ui.rd_data_valid) begin
                cq.push_back(ui.rd_data);
                ce.push_back(ui.rd_data_end);
                cj.push_back(j);
            end
            @(negedge memory_clk);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " cmd_ready"},     ui.cmd_ready, 0);
        chk({tag, " wr_data_rdy"},   ui.wr_data_rdy, 0);
        chk({tag, " rd_data"},       ui.rd_data, 0);
        chk({tag, " rd_data_valid"}, ui.rd_data_valid, 0);
        chk({tag, " rd_data_end"},   ui.rd_data_end, 0);
        chk({tag, " ref_ack"},       ui.ref_ack, 0);
        chk({tag, " calib"},         ui.init_calib_complete, 0);
        chk({tag, " proto_err"},     ui.proto_err, 0);
    endtask

    task automatic calib_seq();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge memory_clk);
            chk($sformatf("calib edge%0d", k), ui.init_calib_complete, (k >= 8) ? 1 : 0);
            chk($sformatf("calib ready edge%0d", k), ui.cmd_ready, (k >= 8) ? 1 : 0);
            chk($sformatf("calib no valid edge%0d", k), ui.rd_data_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_j;
        logic drop;
        logic [7:0] k8;

        vt[0] = '{28'h10, 128'h00112233445566778899AABBCCDDEEFF, 16'h0000, 128'h00112233445566778899AABBCCDDEEFF};
        vt[1] = '{28'h17, {4{32'hFFFFFFFF}}, 16'hFFFF, 128'h00112233445566778899AABBCCDDEEFF};
        vt[2] = '{28'h10, 128'h0, 16'h00F0, 128'h0000000000000000_8899AABB_00000000};
        vt[3] = '{28'h800, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 16'h0000, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF};
        vt[4] = '{28'h18, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, 16'h8000, 128'h00A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5};
        for (int k = 0; k < 4; k++) begin
            k8 = 8'h10 + 8'(k);
            bw[k] = {16{k8}};
            dw[k] = {4{32'hC0DE0000 + 32'(k)}};
        end
        pre_val = 128'h0123456789ABCDEF_0123456789ABCDEF;

        ui.cmd = '0; ui.cmd_en = 0; ui.addr = '0; ui.app_burst_number = '0;
        ui.wr_data = '0; ui.wr_data_en = 0; ui.wr_data_end = 0; ui.wr_data_mask = '0; ui.ref_req = 0;

        repeat (3) @(negedge memory_clk);
        check_outputs_zero("reset");
        calib_seq();

        for (int i = 0; i < 5; i++) begin
            issue_cmd(3'd0, vt[i].addr, 6'd0);
            write_beat(vt[i].wdat, vt[i].mask, 1'b1);
            issue_cmd(3'd1, vt[i].addr, 6'd0);
            collect(10);
            chk($sformatf("vec%0d beats", i), cq.size(), 1);
            chk($sformatf("vec%0d latency", i), cj[0], RD_LAT);
            chk($sformatf("vec%0d data", i), cq[0], vt[i].exp);
            chk($sformatf("vec%0d end", i), ce[0], 1);
        end
        chk("proto_err clean", ui.proto_err, 0);

        issue_cmd(3'd2, 28'h0, 6'd0);
        chk("ignored cmd stays idle", ui.cmd_ready, 1);

        // Masked, wrapping 4-beat burst over idx 254,255,0,1
        issue_cmd(3'd0, 28'h7F8, 6'd0);
        write_beat(pre_val, 16'h0, 1'b1);
        issue_cmd(3'd0, 28'h7F0, 6'd3);
        for (int k = 0; k < 4; k++) begin
            ui.wr_data = bw[k]; ui.wr_data_mask = (k == 1) ? 16'h0001 : 16'h0000;
            ui.wr_data_end = (k == 3); ui.wr_data_en = 1'b1;
            @(negedge memory_clk);
        end
        ui.wr_data_en = 0; ui.wr_data_end = 0; ui.wr_data_mask = '0;
        chk("burst wr_rdy done", ui.wr_data_rdy, 0);
        issue_cmd(3'd1, 28'h7F0, 6'd3);
        collect(12);
        chk("burst beats", cq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            exp_v = (k == 1) ? {bw[1][127:8], pre_val[7:0]} : bw[k];
            chk($sformatf("burst data%0d", k), cq[k], exp_v);
            chk($sformatf("burst end%0d", k), ce[k], (k == 3) ? 1 : 0);
            chk($sformatf("burst pos%0d", k), cj[k], RD_LAT + k);
        end
        chk("proto_err after burst", ui.proto_err, 0);

        // Back-to-back reads; second cmd_en held until accepted
        ui.cmd = 3'd1; ui.addr = 28'h7F0; ui.app_burst_number = 6'd3; ui.cmd_en = 1'b1;
        @(posedge memory_clk);
        cq.delete(); ce.delete(); cj.delete();
        drop = 0; acc_j = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge memory_clk);
            if (drop) begin ui.cmd_en = 0; drop = 0; end
            if (j == 0) ui.addr = 28'h10;
            if (ui.rd_data_valid) begin
                cq.push_back(ui.rd_data); ce.push_back(ui.rd_data_end); cj.push_back(j);
            end
            if (ui.cmd_en && ui.cmd_ready) begin drop = 1; acc_j = j; end
        end
        chk("b2b second accept", acc_j, 4);
        chk("b2b beats", cq.size(), 8);
        for (int k = 0; k < 8; k++) begin
            case (k)
                0, 2, 3: exp_v = bw[k];
                1:       exp_v = {bw[1][127:8], pre_val[7:0]};
                4:       exp_v = vt[2].exp;
                5:       exp_v = vt[4].exp;
                default: exp_v = '0;
            endcase
            chk($sformatf("b2b data%0d", k), cq[k], exp_v);
            chk($sformatf("b2b end%0d", k), ce[k], (k == 3 || k == 7) ? 1 : 0);
            chk($sformatf("b2b pos%0d", k), cj[k], (k < 4) ? RD_LAT + k : RD_LAT + 5 + (k - 4));
        end
        chk("b2b proto_err", ui.proto_err, 1);

        // Reset in the middle of a read burst
        issue_cmd(3'd1, 28'h7F0, 6'd3);
        collect(5);
        chk("mid-read valid in flight", ui.rd_data_valid, 1);
        rst_n = 1'b0;
        @(negedge memory_clk);
        check_outputs_zero("mid-read reset");
        @(negedge memory_clk);
        calib_seq();
        issue_cmd(3'd1, 28'h7F0, 6'd0);
        collect(8);
        chk("mem kept across reset", cq[0], bw[0]);
        chk("proto_err after reset", ui.proto_err, 0);

        // Refresh collides with a command
        ui.ref_req = 1; ui.cmd = 3'd1; ui.addr = 28'h10; ui.app_burst_number = 6'd0; ui.cmd_en = 1;
        @(posedge memory_clk);
        @(negedge memory_clk);
        ui.ref_req = 0; ui.cmd_en = 0;
        for (int j = 0; j < 7; j++) begin
            chk($sformatf("ref ack j%0d", j), ui.ref_ack, (j == 5) ? 1 : 0);
            chk($sformatf("ref ready j%0d", j), ui.cmd_ready, (j == 6) ? 1 : 0);
            chk($sformatf("ref no read j%0d", j), ui.rd_data_valid, 0);
            @(negedge memory_clk);
        end
        chk("ref collision proto_err", ui.proto_err, 1);
        issue_cmd(3'd1, 28'h10, 6'd0);
        collect(8);
        chk("retry beats", cq.size(), 1);
        chk("retry data", cq[0], vt[2].exp);
        chk("retry latency", cj[0], RD_LAT);

        // wr_data_end on beat 2 of 4
        rst_n = 1'b0;
        @(negedge memory_clk);
        calib_seq();
        chk("proto_err cleared", ui.proto_err, 0);
        issue_cmd(3'd0, 28'h20, 6'd3);
        for (int k = 0; k < 4; k++) begin
            ui.wr_data = dw[k]; ui.wr_data_mask = '0; ui.wr_data_end = (k == 1); ui.wr_data_en = 1'b1;
            @(negedge memory_clk);
            if (k == 1 || k == 2) begin
                chk($sformatf("early end proto_err k%0d", k), ui.proto_err, 1);
                chk($sformatf("early end burst open k%0d", k), ui.wr_data_rdy, 1);
            end
        end
        ui.wr_data_en = 0; ui.wr_data_end = 0;
        chk("early end wr_rdy closed", ui.wr_data_rdy, 0);
        chk("early end cmd_ready", ui.cmd_ready, 1);
        issue_cmd(3'd1, 28'h20, 6'd3);
        collect(12);
        chk("early end beats", cq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("early end data%0d", k), cq[k], dw[k]);
            chk($sformatf("early end rd_end%0d", k), ce[k], (k == 3) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
